// File: rtl/frame_pixel_server.sv
// frame_pixel_server: single-port frame RAM arbiter that serves pixel reads
// alongside the camera write stream. Writes win the port, but a read that has
// been deferred MAX_DEFER times forces its way in and drops the coincident write.
module frame_pixel_server #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int ADDR_W    = 19,
  parameter int RAM_LAT   = 2,
  parameter int MAX_DEFER = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_request,
  input  logic [9:0]        mem_hcount,
  input  logic [9:0]        mem_vcount,
  output logic [8:0]        mem_pixel_data,
  output logic              mem_valid,
  output logic              mem_busy,
  input  logic              wr_en,
  input  logic [9:0]        wr_hcount,
  input  logic [9:0]        wr_vcount,
  input  logic [8:0]        wr_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [8:0]        ram_wdata,
  input  logic [8:0]        ram_rdata,
  output logic [15:0]       wr_dropped
);

  localparam int DW = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;
  localparam int LW = (RAM_LAT > 0) ? $clog2(RAM_LAT + 1) : 1;
  localparam logic [9:0]    H_LIM    = 10'(H_ACTIVE);
  localparam logic [9:0]    V_LIM    = 10'(V_ACTIVE);
  localparam logic [DW-1:0] DEF_MAX  = DW'(MAX_DEFER);
  localparam logic [LW-1:0] LAT_LAST = LW'(RAM_LAT);

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_WAIT} state_t;

  state_t            state_q, state_d;
  logic [9:0]        h_q, h_d, v_q, v_d;
  logic              oor_q, oor_d;
  logic [DW-1:0]     defer_q, defer_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [8:0]        ram_wdata_q, ram_wdata_d;
  logic [8:0]        pix_q, pix_d;
  logic              valid_q, valid_d;
  logic [15:0]       drop_q, drop_d;

  logic wr_ok, accept, grant_wr, done;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [9:0] h, input logic [9:0] v);
    logic [ADDR_W-1:0] he, ve;
    he = ADDR_W'(h);
    ve = ADDR_W'(v);
    if (H_ACTIVE == 640) return (ve << 9) + (ve << 7) + he;
    else                 return ve * ADDR_W'(H_ACTIVE) + he;
  endfunction

  assign wr_ok = wr_en && (wr_hcount < H_LIM) && (wr_vcount < V_LIM);
  // The final WAIT cycle reports not-busy so a new request can be accepted on
  // the same edge that returns the previous pixel.
  assign done     = (state_q == ST_WAIT) && (lat_q == LAT_LAST);
  assign mem_busy = (state_q != ST_IDLE) && !done;
  assign accept   = mem_request && !mem_busy;

  // Next-state, port arbitration and output register inputs
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    oor_d       = oor_q;
    defer_d     = defer_q;
    lat_d       = lat_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    pix_d       = pix_q;
    valid_d     = 1'b0;
    drop_d      = drop_q;
    grant_wr    = wr_ok;
    case (state_q)
      ST_PEND: begin
        if (oor_q) begin
          state_d = ST_WAIT;
          lat_d   = '0;
          defer_d = '0;
        end else if (!wr_ok || defer_q == DEF_MAX) begin
          ram_addr_d = addr_of(h_q, v_q);
          state_d    = ST_WAIT;
          lat_d      = '0;
          defer_d    = '0;
          grant_wr   = 1'b0;
          if (wr_ok && drop_q != '1) drop_d = drop_q + 16'd1;
        end else begin
          defer_d = defer_q + DW'(1);
        end
      end
      ST_WAIT: begin
        if (done) begin
          pix_d   = oor_q ? '0 : ram_rdata;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      default: ;
    endcase
    if (accept) begin
      h_d     = mem_hcount;
      v_d     = mem_vcount;
      oor_d   = (mem_hcount >= H_LIM) || (mem_vcount >= V_LIM);
      state_d = ST_PEND;
    end
    if (grant_wr) begin
      ram_addr_d  = addr_of(wr_hcount, wr_vcount);
      ram_we_d    = 1'b1;
      ram_wdata_d = wr_data;
    end
  end

  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      h_q         <= '0;
      v_q         <= '0;
      oor_q       <= 1'b0;
      defer_q     <= '0;
      lat_q       <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      pix_q       <= '0;
      valid_q     <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      oor_q       <= oor_d;
      defer_q     <= defer_d;
      lat_q       <= lat_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      pix_q       <= pix_d;
      valid_q     <= valid_d;
      drop_q      <= drop_d;
    end
  end

  assign mem_pixel_data = pix_q;
  assign mem_valid      = valid_q;
  assign ram_addr       = ram_addr_q;
  assign ram_we         = ram_we_q;
  assign ram_wdata      = ram_wdata_q;
  assign wr_dropped     = drop_q;

endmodule

// File: tb/tb_frame_pixel_server.sv
// Scoreboard bench for frame_pixel_server with a 2-cycle-latency RAM model.
module tb_frame_pixel_server;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_request = 1'b0;
  logic [9:0]  mem_hcount = '0, mem_vcount = '0;
  logic [8:0]  mem_pixel_data;
  logic        mem_valid, mem_busy;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_hcount = '0, wr_vcount = '0;
  logic [8:0]  wr_data = '0;
  logic [18:0] ram_addr;
  logic        ram_we;
  logic [8:0]  ram_wdata;
  logic [8:0]  ram_rdata;
  logic [15:0] wr_dropped;

  frame_pixel_server #(.H_ACTIVE(640), .V_ACTIVE(480), .ADDR_W(19), .RAM_LAT(2), .MAX_DEFER(4)) dut (
    .clk(clk), .reset(reset),
    .mem_request(mem_request), .mem_hcount(mem_hcount), .mem_vcount(mem_vcount),
    .mem_pixel_data(mem_pixel_data), .mem_valid(mem_valid), .mem_busy(mem_busy),
    .wr_en(wr_en), .wr_hcount(wr_hcount), .wr_vcount(wr_vcount), .wr_data(wr_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .wr_dropped(wr_dropped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: address sampled one edge after issue, data out on the next
  logic [8:0] mem [0:(1<<19)-1];
  logic [8:0] st1;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    st1       <= mem[ram_addr];
    ram_rdata <= st1;
  end

  typedef struct packed {
    logic [8:0] d;
    int         at;
  } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;

  // Monitor: every mem_valid must match the oldest expected pixel and cycle
  always @(negedge clk) begin
    if (mem_valid) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: cyc=%0d data=%h, none expected", cyc, mem_pixel_data);
      end else begin
        e = q.pop_front();
        if (mem_pixel_data !== e.d || cyc != e.at) begin
          errors++;
          $display("FAIL read_return: got data=%h at cyc %0d, want data=%h at cyc %0d",
                   mem_pixel_data, cyc, e.d, e.at);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h), want %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  task automatic do_write(input logic [9:0] h, input logic [9:0] v, input logic [8:0] d,
                          input logic [18:0] exp_addr);
    wr_en = 1'b1; wr_hcount = h; wr_vcount = v; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    chk("wr_we", 32'(ram_we), 32'd1);
    chk("wr_addr", 32'(ram_addr), 32'(exp_addr));
    chk("wr_data", 32'(ram_wdata), 32'(d));
  endtask

  task automatic read_req(input logic [9:0] h, input logic [9:0] v, input logic [8:0] d,
                          input int lat);
    exp_t e;
    mem_request = 1'b1; mem_hcount = h; mem_vcount = v;
    @(negedge clk);
    e.d = d; e.at = cyc + lat;
    q.push_back(e);
    mem_request = 1'b0; mem_hcount = '0; mem_vcount = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d reads outstanding, want 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int t;
    repeat (3) @(negedge clk);
    chk("rst_pix", 32'(mem_pixel_data), 0);
    chk("rst_valid", 32'(mem_valid), 0);
    chk("rst_busy", 32'(mem_busy), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_dropped", 32'(wr_dropped), 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: basic read of (5,2) -> addr 1285
    do_write(10'd5, 10'd2, 9'h0AB, 19'd1285);
    do_write(10'd0, 10'd1, 9'h1FF, 19'd640);
    read_req(10'd5, 10'd2, 9'h0AB, 4);
    @(negedge clk);
    chk("t1_issue_addr", 32'(ram_addr), 1285);
    chk("t1_issue_we", 32'(ram_we), 0);
    chk("t1_busy", 32'(mem_busy), 1);
    drain();

    // 2: far corner pixel
    do_write(10'd639, 10'd479, 9'h1C7, 19'd307199);
    read_req(10'd639, 10'd479, 9'h1C7, 4);
    @(negedge clk);
    chk("t2_issue_addr", 32'(ram_addr), 307199);
    drain();

    // 3: continuous writes defer the read four times, fifth forces it
    chk("t3_drop_before", 32'(wr_dropped), 0);
    wr_en = 1'b1; wr_hcount = 10'd10; wr_vcount = 10'd10; wr_data = 9'h055;
    mem_request = 1'b1; mem_hcount = 10'd5; mem_vcount = 10'd2;
    @(negedge clk);
    e.d = 9'h0AB; e.at = cyc + 8;
    q.push_back(e);
    mem_request = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t3_defer_we", 32'(ram_we), 1);
      chk("t3_defer_addr", 32'(ram_addr), 6410);
    end
    @(negedge clk);
    chk("t3_forced_addr", 32'(ram_addr), 1285);
    chk("t3_forced_we", 32'(ram_we), 0);
    chk("t3_drop_after", 32'(wr_dropped), 1);
    @(negedge clk);
    chk("t3_write_resume", 32'(ram_we), 1);
    drain();
    wr_en = 1'b0;
    @(negedge clk);
    chk("t3_drop_final", 32'(wr_dropped), 1);

    // 4: out-of-range read returns 0 without touching the port
    read_req(10'd640, 10'd0, 9'h000, 4);
    @(negedge clk);
    chk("t4_addr_kept", 32'(ram_addr), 6410);
    chk("t4_no_we", 32'(ram_we), 0);
    drain();

    // 5a: request held high -> accepts every 4 cycles
    mem_request = 1'b1; mem_hcount = 10'd5; mem_vcount = 10'd2;
    @(negedge clk);
    t = cyc;
    for (int k = 1; k <= 3; k++) begin
      e.d = 9'h0AB; e.at = t + 4 * k;
      q.push_back(e);
    end
    repeat (8) @(negedge clk);
    mem_request = 1'b0;
    drain();
    chk("t5_idle", 32'(mem_busy), 0);

    // 5b: a pulse while busy is ignored
    read_req(10'd639, 10'd479, 9'h1C7, 4);
    mem_request = 1'b1; mem_hcount = 10'd5; mem_vcount = 10'd2;
    @(negedge clk);
    mem_request = 1'b0;
    drain();
    repeat (6) @(negedge clk);

    // 6: reset during WAIT discards the read
    read_req(10'd5, 10'd2, 9'h0AB, 4);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_rst_pix", 32'(mem_pixel_data), 0);
    chk("t6_rst_busy", 32'(mem_busy), 0);
    chk("t6_rst_addr", 32'(ram_addr), 0);
    chk("t6_rst_dropped", 32'(wr_dropped), 0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_post_busy", 32'(mem_busy), 0);
    chk("t6_post_pix", 32'(mem_pixel_data), 0);

    chk("leftover_expect", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
